// File: rtl/rv_boot_sequencer.sv
// Boot sequencer for the single-cycle RV32 core: streams a program image into instruction memory
// while the core is held in reset, then runs it until a mailbox store or the cycle budget expires.
module rv_boot_sequencer #(
   parameter int unsigned IMEM_AW    = 10,
   parameter logic [31:0] HALT_ADDR  = 32'hFFFF_FFFC,
   parameter logic [31:0] MAX_CYCLES = 32'd100000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [IMEM_AW:0]   load_len,
   input  logic               s_valid,
   input  logic [31:0]        s_data,
   output logic               s_ready,
   output logic               imem_we,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic [31:0]        imem_wdata,
   output logic               core_reset,
   input  logic               core_we,
   input  logic [31:0]        core_addr,
   input  logic [31:0]        core_wdata,
   output logic               busy,
   output logic               done,
   output logic               timeout,
   output logic [31:0]        result,
   output logic [31:0]        cycle_count
);

   localparam logic [IMEM_AW:0] MaxLen = {1'b1, {IMEM_AW{1'b0}}};
   localparam logic [IMEM_AW:0] LenOne = {{IMEM_AW{1'b0}}, 1'b1};
   localparam logic [IMEM_AW:0] LenZero = '0;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StRelease,
      StRun,
      StDone,
      StTmo
   } state_e;

   state_e             state_q, state_d;
   logic [IMEM_AW:0]   len_q, len_d;
   logic [IMEM_AW:0]   cnt_q, cnt_d;
   logic [IMEM_AW:0]   len_clamped;
   logic               imem_we_d;
   logic [IMEM_AW-1:0] imem_addr_d;
   logic [31:0]        imem_wdata_d;
   logic               busy_d;
   logic               done_d;
   logic               timeout_d;
   logic [31:0]        result_d;
   logic [31:0]        cycle_count_d;
   logic               xfer;
   logic               halt_hit;
   logic               budget_hit;

   assign s_ready    = (state_q == StLoad);
   assign core_reset = (state_q != StRun);

   always_comb begin
      len_clamped   = (load_len > MaxLen) ? MaxLen : load_len;
      xfer          = s_valid & s_ready;
      halt_hit      = core_we && (core_addr == HALT_ADDR);
      // A zero budget disables the timeout entirely, letting cycle_count wrap.
      budget_hit    = (MAX_CYCLES != 32'd0) && (cycle_count == MAX_CYCLES - 32'd1);

      state_d       = state_q;
      len_d         = len_q;
      cnt_d         = cnt_q;
      imem_we_d     = 1'b0;
      imem_addr_d   = imem_addr;
      imem_wdata_d  = imem_wdata;
      done_d        = done;
      timeout_d     = timeout;
      result_d      = result;
      cycle_count_d = cycle_count;

      unique case (state_q)
         StIdle, StDone, StTmo: begin
            if (start) begin
               done_d    = 1'b0;
               timeout_d = 1'b0;
               len_d     = len_clamped;
               cnt_d     = LenZero;
               state_d   = (len_clamped != LenZero) ? StLoad : StRelease;
            end
         end
         StLoad: begin
            if (xfer) begin
               imem_we_d    = 1'b1;
               imem_addr_d  = cnt_q[IMEM_AW-1:0];
               imem_wdata_d = s_data;
               cnt_d        = cnt_q + LenOne;
               if (cnt_q == len_q - LenOne) begin
                  state_d = StRelease;
               end
            end
         end
         StRelease: begin
            cycle_count_d = 32'd0;
            state_d       = StRun;
         end
         StRun: begin
            cycle_count_d = cycle_count + 32'd1;
            // Mailbox store takes priority over a budget expiring in the same cycle.
            if (halt_hit) begin
               state_d  = StDone;
               result_d = core_wdata;
               done_d   = 1'b1;
            end else if (budget_hit) begin
               state_d   = StTmo;
               timeout_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      busy_d = (state_d == StLoad) || (state_d == StRelease) || (state_d == StRun);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         len_q       <= '0;
         cnt_q       <= '0;
         imem_we     <= 1'b0;
         imem_addr   <= '0;
         imem_wdata  <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         timeout     <= 1'b0;
         result      <= '0;
         cycle_count <= '0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         imem_we     <= imem_we_d;
         imem_addr   <= imem_addr_d;
         imem_wdata  <= imem_wdata_d;
         busy        <= busy_d;
         done        <= done_d;
         timeout     <= timeout_d;
         result      <= result_d;
         cycle_count <= cycle_count_d;
      end
   end

endmodule

// File: tb/tb_rv_boot_sequencer.sv
// Bench for rv_boot_sequencer: a tiny RV32 core model executes the loaded image while a
// program-level model predicts halt/timeout outcome, cycle count and the image writes.
module tb_rv_boot_sequencer;

   localparam int unsigned AW     = 6;
   localparam int          Depth  = 64;
   localparam int          MaxCyc = 8;
   localparam logic [31:0] Nop    = 32'h0000_0013;
   localparam logic [31:0] Jal0   = 32'h0000_006F;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [AW:0]   load_len = '0;
   logic          s_valid = 1'b0;
   logic [31:0]   s_data = '0;
   logic          s_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          core_reset;
   logic          core_we;
   logic [31:0]   core_addr;
   logic [31:0]   core_wdata;
   logic          busy, done, timeout;
   logic [31:0]   result, cycle_count;

   always #5 clk = ~clk;

   rv_boot_sequencer #(
      .IMEM_AW   (AW),
      .HALT_ADDR (32'hFFFF_FFFC),
      .MAX_CYCLES(32'd8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .load_len   (load_len),
      .s_valid    (s_valid),
      .s_data     (s_data),
      .s_ready    (s_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_reset (core_reset),
      .core_we    (core_we),
      .core_addr  (core_addr),
      .core_wdata (core_wdata),
      .busy       (busy),
      .done       (done),
      .timeout    (timeout),
      .result     (result),
      .cycle_count(cycle_count)
   );

   // Instruction memory and write log
   logic [31:0] mem [Depth];
   int          wlog_addr[$];
   logic [31:0] wlog_data[$];
   int          drop_gap[$];
   int          cyc = 0;
   int          last_we_cyc = 0;
   logic        prev_cr = 1'b1;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (imem_we) begin
         mem[imem_addr] <= imem_wdata;
         wlog_addr.push_back(int'(imem_addr));
         wlog_data.push_back(imem_wdata);
         last_we_cyc <= cyc;
      end
      if (prev_cr && !core_reset) drop_gap.push_back(cyc - last_we_cyc);
      prev_cr <= core_reset;
   end

   // Minimal single-cycle core: addi, sw, jal; anything else advances pc
   logic [31:0] pc;
   logic [31:0] rf [32];
   logic [31:0] instr, iimm, simm, jimm;
   logic [6:0]  opc;
   logic [4:0]  rd, rs1, rs2;

   always_comb begin
      instr      = mem[pc[7:2]];
      opc        = instr[6:0];
      rd         = instr[11:7];
      rs1        = instr[19:15];
      rs2        = instr[24:20];
      iimm       = {{20{instr[31]}}, instr[31:20]};
      simm       = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      jimm       = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      core_we    = (opc == 7'h23);
      core_addr  = rf[rs1] + simm;
      core_wdata = rf[rs2];
   end

   always @(posedge clk) begin
      if (core_reset) begin
         pc <= 32'd0;
         for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
      end else begin
         if (opc == 7'h13 && rd != 5'd0) rf[rd] <= rf[rs1] + iimm;
         pc <= (opc == 7'h6F) ? pc + jimm : pc + 32'd4;
      end
   end

   int          n_checks = 0;
   int          n_pass = 0;
   logic [31:0] exp_result = 32'd0;
   logic [31:0] img[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] addi_x1(input logic [11:0] imm);
      return {imm, 5'd0, 3'b000, 5'd1, 7'h13};
   endfunction

   function automatic logic [31:0] sw_x1(input logic [11:0] off);
      return {off[11:5], 5'd1, 5'd0, 3'b010, off[4:0], 7'h23};
   endfunction

   task automatic build_prog(input int nops, input logic [31:0] imm);
      img.delete();
      for (int i = 0; i < nops; i++) img.push_back(Nop);
      img.push_back(addi_x1(imm[11:0]));
      img.push_back(sw_x1(12'hFFC));
      img.push_back(Jal0);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int len);
      start    = 1'b1;
      load_len = len[AW:0];
      tick();
      start    = 1'b0;
      load_len = '0;
   endtask

   // mode 0: continuous valid, 1: pattern 1,0,0,1,0,1, 2: random gaps
   task automatic stream(input string tag, input int n, input int mode);
      int          i = 0;
      int          k = 0;
      logic        v;
      logic [5:0]  pat = 6'b101001;
      while (i < n && k < 2000) begin
         if (mode == 0) v = 1'b1;
         else if (mode == 1) v = pat[k % 6];
         else v = 1'($urandom_range(0, 1));
         s_valid = v;
         s_data  = img[i];
         if (v && s_ready) i++;
         tick();
         k++;
      end
      s_valid = 1'b0;
      check({tag, "_words_accepted"}, i, n);
   endtask

   task automatic wait_end(input string tag);
      int k = 0;
      while (!(done || timeout) && k < 200) begin
         tick();
         k++;
      end
      check({tag, "_run_ended"}, done | timeout, 1);
   endtask

   // Program-level outcome: the halting store at index h ends the run in cycle h+1
   task automatic predict(input int halt_idx, input logic [31:0] imm,
                          output logic e_done, output logic e_tmo, output logic [31:0] e_cnt);
      if (halt_idx >= 0 && halt_idx + 1 <= MaxCyc) begin
         e_done     = 1'b1;
         e_tmo      = 1'b0;
         e_cnt      = 32'(halt_idx + 1);
         exp_result = imm;
      end else begin
         e_done = 1'b0;
         e_tmo  = 1'b1;
         e_cnt  = 32'(MaxCyc);
      end
   endtask

   task automatic check_writes(input string tag, input int base, input int n);
      int bad = 0;
      check({tag, "_write_count"}, wlog_addr.size() - base, n);
      for (int i = 0; i < n && base + i < wlog_addr.size(); i++) begin
         if (wlog_addr[base + i] != i || wlog_data[base + i] !== img[i]) bad++;
      end
      check({tag, "_write_order"}, bad, 0);
   endtask

   task automatic run_case(input string tag, input int len, input int nwords, input int mode,
                           input int halt_idx, input logic [31:0] imm);
      int          base;
      logic        e_done, e_tmo;
      logic [31:0] e_cnt;
      base = wlog_addr.size();
      predict(halt_idx, imm, e_done, e_tmo, e_cnt);
      do_start(len);
      stream(tag, nwords, mode);
      check({tag, "_ready_after_load"}, s_ready, 0);
      wait_end(tag);
      check_writes(tag, base, nwords);
      if (nwords > 0) check({tag, "_release_gap"}, drop_gap[$], 1);
      check({tag, "_done"}, done, e_done);
      check({tag, "_timeout"}, timeout, e_tmo);
      check({tag, "_cycles"}, cycle_count, e_cnt);
      check({tag, "_result"}, result, exp_result);
      check({tag, "_core_reset"}, core_reset, 1);
      check({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      int          base;
      int          nops;
      logic [31:0] imm;

      // Reset state
      #1;
      check("rst_core_reset", core_reset, 1);
      check("rst_s_ready", s_ready, 0);
      check("rst_imem_we", imem_we, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_timeout", timeout, 0);
      check("rst_result", result, 0);
      check("rst_cycles", cycle_count, 0);
      tick();
      tick();
      reset = 1'b0;
      tick();

      // Load and halt with continuous valid, then with backpressure
      build_prog(0, 32'd5);
      run_case("load_halt", 3, 3, 0, 1, 32'd5);
      run_case("backpressure", 3, 3, 1, 1, 32'd5);

      // Budget expiry on a spinning image
      img.delete();
      img.push_back(Jal0);
      run_case("timeout", 1, 1, 0, -1, 32'd0);

      // Halt store in the final budget cycle
      build_prog(6, 32'd33);
      run_case("halt_vs_budget", img.size(), img.size(), 0, 7, 32'd33);

      // Reset in the middle of a load
      img.delete();
      img.push_back(addi_x1(12'd7));
      img.push_back(sw_x1(12'd8));
      img.push_back(sw_x1(12'hFFC));
      img.push_back(Jal0);
      do_start(4);
      stream("partial", 2, 0);
      reset = 1'b1;
      #1;
      exp_result = 32'd0;
      check("midload_s_ready", s_ready, 0);
      check("midload_core_reset", core_reset, 1);
      check("midload_busy", busy, 0);
      check("midload_imem_addr", imem_addr, 0);
      check("midload_result", result, 0);
      tick();
      reset = 1'b0;
      tick();
      run_case("reload", 4, 4, 0, 2, 32'd7);

      // Zero-length rerun of the resident image; start during RUN is ignored
      base = wlog_addr.size();
      do_start(0);
      check("rerun_done_cleared", done, 0);
      check("rerun_busy", busy, 1);
      check("rerun_release_core_reset", core_reset, 1);
      tick();
      check("rerun_run_core_reset", core_reset, 0);
      start    = 1'b1;
      load_len = 7'd5;
      tick();
      start    = 1'b0;
      load_len = '0;
      wait_end("rerun");
      check("rerun_no_writes", wlog_addr.size() - base, 0);
      check("rerun_done", done, 1);
      check("rerun_result", result, 7);
      check("rerun_cycles", cycle_count, 3);

      // Over-long load_len clamps to the memory depth
      build_prog(0, 32'd9);
      while (img.size() < Depth) img.push_back(Nop);
      run_case("clamp", Depth + int'($urandom_range(1, 63)), Depth, 2, 1, 32'd9);

      // Randomized programs with random stream gaps
      for (int t = 0; t < 6; t++) begin
         nops = int'($urandom_range(0, 7));
         imm  = 32'($urandom_range(1, 2047));
         build_prog(nops, imm);
         run_case($sformatf("rand%0d", t), img.size(), img.size(), 2, nops + 1, imm);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
